// File: rtl/sram_stream_reader.sv
// sram_stream_reader: Avalon-MM read master that streams a contiguous block of words out of
// the shared SRAM into a local FIFO and presents them on a ready/valid stream.
//
// A start command latches a base address and word count. Reads are then issued back to back
// while credit is available: outstanding reads plus buffered words must stay below FIFO_DEPTH.
// Returned data is pushed into the FIFO, and cmd_done pulses once every issued read is back.
//
// Ports:
//   clock, reset_n        system clock, asynchronous active-low reset
//   cmd_start/addr/len    start pulse (sampled only when idle), first word address, word count
//   cmd_abort             abort request (only with SRAM_STREAM_READER_ABORT_EN defined)
//   cmd_busy, cmd_done    busy while a transfer runs; one-cycle completion pulse
//   err_unexpected        sticky: read data arrived with no read outstanding
//   m_*                   Avalon-MM read master towards the SRAM arbiter
//   out_data/valid/ready  output stream; out_data is the FIFO head
//
// Optional feature: define SRAM_STREAM_READER_ABORT_EN to add cmd_abort.
module sram_stream_reader #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_start,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
`ifdef SRAM_STREAM_READER_ABORT_EN
  input  logic                  cmd_abort,
`endif
  output logic                  cmd_busy,
  output logic                  cmd_done,
  output logic                  err_unexpected,
  output logic [ADDR_WIDTH-1:0] m_address,
  output logic [BE_WIDTH-1:0]   m_byteenable,
  output logic                  m_read,
  input  logic [DATA_WIDTH-1:0] m_readdata,
  input  logic                  m_readdataready,
  input  logic                  m_waitrequest,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d, issued_inc;
  logic [CntW-1:0]       outst_q, outst_d;
  logic                  err_q, err_d;
  logic                  discard_q, discard_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;

  logic abort;
  logic abort_act;
  logic accept;
  logic resp_ok;
  logic push;
  logic pop;
  logic credit;
  logic last_accept;

`ifdef SRAM_STREAM_READER_ABORT_EN
  assign abort = cmd_abort;
`else
  assign abort = 1'b0;
`endif

  // Abort only matters while reads are in flight.
  assign abort_act = abort && ((state_q == StIssue) || (state_q == StDrain));

  // Outstanding plus buffered words can never exceed the FIFO, so a push always has room.
  assign credit = ((CntW + 1)'(outst_q) + (CntW + 1)'(count_q)) < (CntW + 1)'(FIFO_DEPTH);

  // While stalled, credit cannot shrink (a push trades one outstanding for one buffered word),
  // so the request stays asserted until accepted.
  assign m_read      = (state_q == StIssue) && credit;
  assign accept      = m_read && !m_waitrequest;
  assign resp_ok     = m_readdataready && (outst_q != '0);
  assign push        = resp_ok && !discard_q && !abort_act;
  assign pop         = out_valid && out_ready;
  assign issued_inc  = issued_q + LEN_WIDTH'(1);
  assign last_accept = accept && (issued_inc == len_q);

  assign cmd_busy       = (state_q != StIdle);
  assign cmd_done       = (state_q == StDone);
  assign err_unexpected = err_q;
  assign m_address      = addr_q;
  assign m_byteenable   = '1;
  assign out_valid      = (count_q != '0);
  assign out_data       = mem_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    issued_d  = issued_q;
    outst_d   = outst_q;
    err_d     = err_q;
    discard_d = discard_q;

    unique case ({accept, resp_ok})
      2'b10:   outst_d = outst_q + CntW'(1);
      2'b01:   outst_d = outst_q - CntW'(1);
      default: outst_d = outst_q;
    endcase

    if (accept) begin
      addr_d   = addr_q + ADDR_WIDTH'(1);
      issued_d = issued_inc;
    end

    if (abort_act) begin
      discard_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_start) begin
          addr_d    = cmd_addr;
          len_d     = cmd_len;
          issued_d  = '0;
          outst_d   = '0;
          err_d     = 1'b0;
          discard_d = 1'b0;
          state_d   = (cmd_len == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (last_accept) begin
          state_d = StDrain;
        end else if ((abort || discard_q) && !(m_read && m_waitrequest)) begin
          // A stalled request must be accepted before the abort can take effect.
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Looking at the next count lets cmd_done follow the last response by one cycle.
        if (outst_d == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Setting takes priority over the clear from a start in the same cycle.
    if (m_readdataready && (outst_q == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      outst_q   <= '0;
      err_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      outst_q   <= outst_d;
      err_q     <= err_d;
      discard_q <= discard_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (abort_act) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= m_readdata;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
